// File: rtl/addr_gen_pkg.sv
// Shared types for the address generator: address modes, FSM states, defaults.
package addr_gen_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;

  // Encoding shared with the address-mode controller.
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_ALU_IR   = 2'd1,
    MODE_MEM      = 2'd2,
    MODE_ALU_DATA = 2'd3
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Instruction fetch beats are NORMAL and branch redirects.
  function automatic logic is_fetch(addr_mode_e m);
    return (m == MODE_NORMAL) || (m == MODE_ALU_IR);
  endfunction

endpackage

// File: rtl/addr_gen_pc_reg.sv
// Program counter register: holds, or advances to base+2 when told to.
module addr_gen_pc_reg #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] PC_RST  = {RESET_PC[ADDR_W-1:1], 1'b0};
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: the address just fetched plus one instruction, wrapping mod 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (i_adv) begin
      pc_d = i_base + PC_STEP;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RST;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc = pc_q;

endmodule

// File: rtl/addr_gen.sv
// Memory address generator: drives the unified memory bus, owns the PC and
// holds a stalled request stable until memory is ready.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_addr_mode,
  input  logic [ADDR_W-1:0] i_alu_result,
  input  logic              i_store,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fetch_valid,
  output logic              o_stall
);

  state_e            state_q, state_d;
  addr_mode_e        req_mode_q, req_mode_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;

  addr_mode_e        cur_mode;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic              mem_req;
  logic              accept;
  logic              pc_adv;
  logic [ADDR_W-1:0] pc;

  // Fetch beats advance the PC from the address actually issued: for NORMAL
  // that is the PC itself, for ALU_IR the aligned branch target, so one adder
  // covers both and also serves the latched request on WAIT completion.
  addr_gen_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .i_adv (pc_adv),
    .i_base(cur_addr),
    .o_pc  (pc)
  );

  // FSM next state, bus selection and request capture.
  always_comb begin
    state_d     = state_q;
    req_mode_d  = req_mode_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    data_addr_d = data_addr_q;
    cur_mode    = MODE_NORMAL;
    cur_addr    = '0;
    cur_we      = 1'b0;
    mem_req     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_req  = 1'b1;
        cur_mode = addr_mode_e'(i_addr_mode);
        case (cur_mode)
          MODE_NORMAL:   cur_addr = pc;
          MODE_ALU_IR:   cur_addr = {i_alu_result[ADDR_W-1:1], 1'b0};
          MODE_MEM:      cur_addr = data_addr_q;
          MODE_ALU_DATA: begin
            cur_addr = i_alu_result;
            cur_we   = i_store;
          end
        endcase
        if (cur_mode == MODE_ALU_DATA) begin
          data_addr_d = i_alu_result;
        end
        if (!i_mem_ready) begin
          state_d    = ST_WAIT;
          req_mode_d = cur_mode;
          req_addr_d = cur_addr;
          req_we_d   = cur_we;
        end
      end
      ST_WAIT: begin
        mem_req  = 1'b1;
        cur_mode = req_mode_q;
        cur_addr = req_addr_q;
        cur_we   = req_we_q;
        if (i_mem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign accept = mem_req & i_mem_ready;
  assign pc_adv = accept & is_fetch(cur_mode);

  // FSM and request-holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      req_mode_q  <= MODE_NORMAL;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      data_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      req_mode_q  <= req_mode_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      data_addr_q <= data_addr_d;
    end
  end

  assign o_mem_req     = mem_req;
  assign o_mem_addr    = cur_addr;
  assign o_mem_we      = cur_we;
  assign o_pc          = pc;
  assign o_fetch_valid = pc_adv;
  assign o_stall       = mem_req & ~i_mem_ready;

endmodule

// File: tb/tb_addr_gen.sv
// Scoreboard bench for addr_gen: driver issues per-cycle stimulus and pushes
// the expected bus picture from a request-level model; monitor pops/compares.
module tb_addr_gen;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] alu = 16'h0000;
  logic        store = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        stall;

  addr_gen #(
    .ADDR_W  (16),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr_mode  (mode),
    .i_alu_result (alu),
    .i_store      (store),
    .i_mem_ready  (ready),
    .o_mem_addr   (mem_addr),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_pc         (pc),
    .o_fetch_valid(fetch_valid),
    .o_stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic        fv;
    logic        stall;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, last data address, one pending request.
  logic [15:0] m_pc = RST_PC;
  logic [15:0] m_data = 16'h0000;
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  int          p_mode = 0;
  logic [15:0] p_addr = 16'h0000;
  logic        p_we = 1'b0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    exp_t e;
    int md;
    logic [15:0] a;
    logic w;
    if (m_boot) begin
      e = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, m_pc};
      m_boot = 1'b0;
    end else begin
      if (m_pend) begin
        md = p_mode; a = p_addr; w = p_we;
      end else begin
        md = int'(mode);
        w = 1'b0;
        case (md)
          0: a = m_pc;
          1: a = alu & 16'hFFFE;
          2: a = m_data;
          default: begin a = alu; w = store; end
        endcase
        if (md == 3) m_data = alu;
      end
      e = '{1'b1, a, w, ready && (md <= 1), !ready, m_pc};
      if (ready) begin
        m_pend = 1'b0;
        if (md == 0) m_pc = m_pc + 16'd2;
        else if (md == 1) m_pc = a + 16'd2;
      end else if (!m_pend) begin
        m_pend = 1'b1; p_mode = md; p_addr = a; p_we = w;
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] md, input logic [15:0] a,
                       input logic st, input logic rd);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = md; alu = a; store = st; ready = rd;
    model_cycle();
  endtask

  // Reset lands mid-cycle so its effect must be asynchronous to be seen.
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    e = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, RST_PC};
    sb.push_back(e);
    m_boot = 1'b1; m_pc = RST_PC; m_data = 16'h0000; m_pend = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("mem_req", 16'(mem_req), 16'(e.req));
      check("mem_addr", mem_addr, e.addr);
      check("mem_we", 16'(mem_we), 16'(e.we));
      check("fetch_valid", 16'(fetch_valid), 16'(e.fv));
      check("stall", 16'(stall), 16'(e.stall));
      check("pc", pc, e.pc);
    end
  end

  initial begin
    do_reset();
    // Sequential fetch after the BOOT cycle.
    for (int i = 0; i < 4; i++) drive(2'd0, 16'h0000, 1'b0, 1'b1);
    // Branch to 0x000E, then the odd target 0x0041.
    drive(2'd1, 16'h000E, 1'b0, 1'b1);
    drive(2'd1, 16'h0041, 1'b0, 1'b1);
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    // Store at unaligned address, then repeat it with MEM mode.
    drive(2'd3, 16'h1235, 1'b1, 1'b1);
    drive(2'd2, 16'h0000, 1'b1, 1'b1);
    // Stall three cycles with changing inputs, accept on the fourth.
    drive(2'd3, 16'h2000, 1'b0, 1'b0);
    drive(2'd1, 16'h5555, 1'b1, 1'b0);
    drive(2'd0, 16'h1111, 1'b0, 1'b0);
    drive(2'd2, 16'h7777, 1'b1, 1'b1);
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    // Branch stalled: fetch flag only on the completing beat.
    drive(2'd1, 16'h0101, 1'b0, 1'b0);
    drive(2'd3, 16'h0202, 1'b1, 1'b1);
    // PC wrap at the top of the address space.
    drive(2'd1, 16'hFFFC, 1'b0, 1'b1);
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    // Reset during WAIT, then MEM before any data access reads address 0.
    drive(2'd3, 16'h3000, 1'b1, 1'b0);
    do_reset();
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    drive(2'd2, 16'h0000, 1'b0, 1'b1);
    drive(2'd0, 16'h0000, 1'b0, 1'b1);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else drive(2'($urandom_range(0, 3)), 16'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_gen.md
# addr_gen

Memory address generator for the 16-bit core: consumes the 2-bit address mode produced by the address-mode controller and drives the unified memory address bus, the program counter and the memory request handshake. It sits between fetch/execute control and the memory port. It owns the PC, applies branch redirects, issues data accesses at ALU-computed addresses and holds the bus stable while memory stalls.

## Interface
- ADDR_W, 16, address and PC width
- RESET_PC, 16'h0000, PC value after reset (bit 0 forced 0)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_addr_mode  in  2  0 NORMAL, 1 ALU_IR (branch), 2 MEM (repeat last data address), 3 ALU_DATA
- i_alu_result  in  ADDR_W  branch target or data address from EX stage
- i_store  in  1  1 = current data access is a store (STR), valid with mode 3
- i_mem_ready  in  1  memory accepts/completes the request this cycle
- o_mem_addr  out  ADDR_W  address on memory bus
- o_mem_req  out  1  request valid
- o_mem_we  out  1  write enable, only for data accesses
- o_pc  out  ADDR_W  address of next instruction fetch
- o_fetch_valid  out  1  current completed beat is an instruction fetch
- o_stall  out  1  pipeline must hold (request outstanding, not ready)

## Operation
- FSM states: BOOT, RUN, WAIT.
- BOOT: entered on reset; o_mem_req=0 for exactly one cycle, then RUN.
- RUN: o_mem_req=1; address/we chosen combinationally from i_addr_mode:
  - NORMAL: addr=pc, we=0, fetch.
  - ALU_IR: addr={i_alu_result[ADDR_W-1:1],1'b0}, we=0, fetch.
  - ALU_DATA: addr=i_alu_result (byte address, no alignment), we=i_store; address also captured into data_addr_q on issue.
  - MEM: addr=data_addr_q, we=0.
- Accept = o_mem_req & i_mem_ready.
  - Accept in NORMAL: pc <= pc+2.
  - Accept in ALU_IR: pc <= aligned target+2.
  - Accept in ALU_DATA/MEM: pc unchanged.
- RUN with i_mem_ready=0: latch mode, addr, we into request registers, go WAIT.
- WAIT: outputs driven from latched registers; i_addr_mode ignored; stay until i_mem_ready=1, then apply the PC rule of the latched mode and return to RUN.
- o_fetch_valid = accept & mode in {NORMAL, ALU_IR} (latched mode in WAIT).
- o_stall = o_mem_req & ~i_mem_ready.
- PC arithmetic mod 2^ADDR_W: 16'hFFFE+2 wraps to 16'h0000.

## Timing
- Reset values: state BOOT, pc=RESET_PC, data_addr_q=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_fetch_valid=0, o_stall=0.
- In RUN, address is valid in the same cycle as i_addr_mode (zero latency); PC update visible on o_pc the cycle after accept.
- In WAIT, o_mem_addr/o_mem_we must not change until the accept cycle (inclusive).
- Branch during WAIT: ignored; controller must re-present mode 1 after stall (o_stall high meanwhile).
- Reset asserted mid-WAIT: outstanding request dropped immediately (o_mem_req=0 asynchronously), pc=RESET_PC.
- MEM mode before any ALU_DATA: address 0.

## Structure
- Shared package: addr_mode enum (NORMAL/ALU_IR/MEM/ALU_DATA, same encoding as the mode controller), ADDR_W default, FSM state typedef.
- Single module; a pc_reg sub-module (load/increment/hold, RESET_PC) is natural but optional.

## Test plan
- Reset release, mode 0, ready=1: one BOOT cycle req=0, then addresses 0,2,4,6; o_fetch_valid=1 each cycle.
- pc=0x0010, mode 1, alu=0x0041, ready=1: addr=0x0040, next o_pc=0x0042, fetch continues at 0x0042.
- Mode 3, alu=0x1235, store=1, ready=1: addr=0x1235, we=1, o_fetch_valid=0, pc held; next cycle mode 2 → addr=0x1235, we=0.
- Mode 3 alu=0x2000 with ready=0 for 3 cycles while mode/alu change: addr=0x2000 and stall=1 held 3 cycles, accept on 4th, then RUN.
- pc=0xFFFE, mode 0 accepted: o_pc=0x0000.
- rst asserted during WAIT: same-cycle req=0, pc=RESET_PC; after release one BOOT cycle then fetch at RESET_PC.
